vme_bus_arbiter: RTL and testbench

Parametrised VME system-controller bus arbiter for the systemboard: it arbitrates `LEVELS` bus-request lines and drives the matching bus-grant daisy-chain outputs. It supports fixed-priority (PRI) or round-robin (RRS) selection, tracks ownership through the BBSY handshake, and asserts BCLR to pre-empt a lower-priority owner. A grant timeout recovers from a grant that no master accepts. It sits on the systemboard CPLD next to the VME address/data monitor logic.

---
 rtl/vme_bus_arbiter_pkg.sv | 24 ++
 rtl/vme_bus_arbiter_if.sv | 43 ++++
 rtl/vme_bus_arbiter_select.sv | 66 ++++++
 rtl/vme_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vme_bus_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package  : vme_pkg
// Brief    : VME signal levels, arbiter state encoding and level-width helper
// Revision : 1.0
//==============================================================================
package vme_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWNED = 2'd2
    } state_t;

    // Width of a level index; never narrower than one bit.
    function automatic int LEVEL_W(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vme_bus_arbiter_if.sv
`default_nettype none
//==============================================================================
// Interface : vme_bus_arbiter_if
// Brief     : VME arbitration lines (BR/BBSY in, BG/BCLR out) plus status
// Revision  : 1.0
//==============================================================================
interface vme_bus_arbiter_if #(
    parameter int LEVELS = 4
);
    import vme_pkg::*;

    localparam int LW = LEVEL_W(LEVELS);

    logic [LEVELS-1:0] br;
    logic              bbsy;
    logic [LEVELS-1:0] bgout;
    logic              bclr;
    logic [LW-1:0]     owner;
    logic              owner_valid;
    logic              grant_timeout;

    modport master (
        input  br,
        input  bbsy,
        output bgout,
        output bclr,
        output owner,
        output owner_valid,
        output grant_timeout
    );

    modport slave (
        output br,
        output bbsy,
        input  bgout,
        input  bclr,
        input  owner,
        input  owner_valid,
        input  grant_timeout
    );

endinterface
`default_nettype wire

// File: rtl/vme_bus_arbiter_select.sv
`default_nettype none
//==============================================================================
// Module   : vme_arb_select
// Brief    : Combinational winner select (fixed priority or round robin)
// Revision : 1.0
//==============================================================================
module vme_arb_select
    import vme_pkg::*;
#(
    parameter  int LEVELS   = 4,
    parameter  int RRS_MODE = 0,
    localparam int LW       = LEVEL_W(LEVELS)
) (
    input  logic [LEVELS-1:0] br_s,
    input  logic [LW-1:0]     last,
    input  logic [LW-1:0]     owner,
    output logic [LW-1:0]     winner,
    output logic              any_req,
    output logic              higher_req
);

    logic [LEVELS-1:0] w_req;
    logic              w_found;
    int                w_idx;

    always_comb begin
        w_req      = '0;
        winner     = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        higher_req = 1'b0;

        for (int i = 0; i < LEVELS; i++) begin
            w_req[i] = (br_s[i] == ACTIVE);
        end
        any_req = |w_req;

        for (int i = 0; i < LEVELS; i++) begin
            if (w_req[i] && (i > int'(owner))) begin
                higher_req = 1'b1;
            end
        end

        if (RRS_MODE == 0) begin
            for (int i = 0; i < LEVELS; i++) begin
                if (w_req[i]) begin
                    winner = LW'(i);
                end
            end
        end else begin
            // Scan upward from last+1, wrapping; last itself is tried last.
            for (int i = 1; i <= LEVELS; i++) begin
                w_idx = int'(last) + i;
                if (w_idx >= LEVELS) begin
                    w_idx = w_idx - LEVELS;
                end
                if (!w_found && w_req[w_idx]) begin
                    winner  = LW'(w_idx);
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vme_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : vme_bus_arbiter
// Brief    : VME system-controller arbiter: BR/BG daisy chain, BBSY, BCLR
// Revision : 1.0
//==============================================================================
module vme_bus_arbiter
    import vme_pkg::*;
#(
    parameter int LEVELS        = 4,
    parameter int RRS_MODE      = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    vme_bus_arbiter_if.master  bus
);

    localparam int LW = LEVEL_W(LEVELS);
    localparam int CW = $clog2(GRANT_TIMEOUT);

    logic [LEVELS-1:0] w_br_s;
    logic              w_bbsy_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_br_s   = bus.br;
        assign w_bbsy_s = bus.bbsy;
    end else begin : g_sync
        logic [LEVELS-1:0] r_br_sync   [SYNC_STAGES];
        logic              r_bbsy_sync [SYNC_STAGES];

        for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
            if (s == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        r_br_sync[s]   <= {LEVELS{INACTIVE}};
                        r_bbsy_sync[s] <= INACTIVE;
                    end else begin
                        r_br_sync[s]   <= bus.br;
                        r_bbsy_sync[s] <= bus.bbsy;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        r_br_sync[s]   <= {LEVELS{INACTIVE}};
                        r_bbsy_sync[s] <= INACTIVE;
                    end else begin
                        r_br_sync[s]   <= r_br_sync[s-1];
                        r_bbsy_sync[s] <= r_bbsy_sync[s-1];
                    end
                end
            end
        end

        assign w_br_s   = r_br_sync[SYNC_STAGES-1];
        assign w_bbsy_s = r_bbsy_sync[SYNC_STAGES-1];
    end

    state_t            r_state,   w_state_nx;
    logic [CW-1:0]     r_count,   w_count_nx;
    logic [LW-1:0]     r_owner,   w_owner_nx;
    logic [LW-1:0]     r_last,    w_last_nx;
    logic [LEVELS-1:0] r_bgout,   w_bgout_nx;
    logic              r_bclr,    w_bclr_nx;
    logic              r_valid,   w_valid_nx;
    logic              r_timeout, w_timeout_nx;

    logic [LW-1:0]     w_winner;
    logic              w_any_req;
    logic              w_higher_req;

    vme_arb_select #(
        .LEVELS   (LEVELS),
        .RRS_MODE (RRS_MODE)
    ) u_select (
        .br_s       (w_br_s),
        .last       (r_last),
        .owner      (r_owner),
        .winner     (w_winner),
        .any_req    (w_any_req),
        .higher_req (w_higher_req)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_owner   <= '0;
            r_last    <= LW'(LEVELS - 1);
            r_bgout   <= {LEVELS{INACTIVE}};
            r_bclr    <= INACTIVE;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_owner   <= w_owner_nx;
            r_last    <= w_last_nx;
            r_bgout   <= w_bgout_nx;
            r_bclr    <= w_bclr_nx;
            r_valid   <= w_valid_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count;
        w_owner_nx   = r_owner;
        w_last_nx    = r_last;
        w_bgout_nx   = {LEVELS{INACTIVE}};
        w_bclr_nx    = INACTIVE;
        w_timeout_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req && (w_bbsy_s == INACTIVE)) begin
                    w_state_nx           = ST_GRANT;
                    w_owner_nx           = w_winner;
                    w_count_nx           = '0;
                    w_bgout_nx[w_winner] = ACTIVE;
                end
            end
            ST_GRANT: begin
                // BBSY is checked first so acceptance beats a coincident timeout.
                if (w_bbsy_s == ACTIVE) begin
                    w_state_nx = ST_OWNED;
                end else if (w_br_s[r_owner] == INACTIVE) begin
                    w_state_nx = ST_IDLE;
                end else if (r_count == CW'(GRANT_TIMEOUT - 1)) begin
                    w_state_nx   = ST_IDLE;
                    w_timeout_nx = 1'b1;
                    w_last_nx    = r_owner;
                end else begin
                    w_count_nx = r_count + CW'(1);
                    w_bgout_nx = r_bgout;
                end
            end
            ST_OWNED: begin
                if (w_bbsy_s == INACTIVE) begin
                    w_state_nx = ST_IDLE;
                    w_last_nx  = r_owner;
                end else if ((RRS_MODE == 0) && w_higher_req) begin
                    w_bclr_nx = ACTIVE;
                end else begin
                    w_bclr_nx = r_bclr;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        w_valid_nx = (w_state_nx != ST_IDLE);
    end

    assign bus.bgout         = r_bgout;
    assign bus.bclr          = r_bclr;
    assign bus.owner         = r_owner;
    assign bus.owner_valid   = r_valid;
    assign bus.grant_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_vme_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_vme_bus_arbiter
// Brief    : Directed bench for three arbiter flavours against a bus-level model
// Revision : 1.0
//==============================================================================
module tb_vme_bus_arbiter;

    localparam int L  = 4;
    localparam int GT = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] br;
    logic       bbsy;

    always #5 clock = ~clock;

    vme_bus_arbiter_if #(.LEVELS(L)) bus0 ();
    vme_bus_arbiter_if #(.LEVELS(L)) bus1 ();
    vme_bus_arbiter_if #(.LEVELS(L)) bus2 ();

    assign bus0.br = br;  assign bus0.bbsy = bbsy;
    assign bus1.br = br;  assign bus1.bbsy = bbsy;
    assign bus2.br = br;  assign bus2.bbsy = bbsy;

    // dut0: PRI no sync, dut1: RRS no sync, dut2: PRI with two sync stages
    vme_bus_arbiter #(.LEVELS(L), .RRS_MODE(0), .SYNC_STAGES(0), .GRANT_TIMEOUT(GT))
        dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
    vme_bus_arbiter #(.LEVELS(L), .RRS_MODE(1), .SYNC_STAGES(0), .GRANT_TIMEOUT(GT))
        dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
    vme_bus_arbiter #(.LEVELS(L), .RRS_MODE(0), .SYNC_STAGES(2), .GRANT_TIMEOUT(GT))
        dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

    logic [3:0] a_bgout [3];
    logic       a_bclr  [3];
    logic       a_valid [3];
    logic       a_to    [3];
    logic [1:0] a_owner [3];

    assign a_bgout[0] = bus0.bgout; assign a_bclr[0] = bus0.bclr; assign a_valid[0] = bus0.owner_valid;
    assign a_to[0]    = bus0.grant_timeout; assign a_owner[0] = bus0.owner;
    assign a_bgout[1] = bus1.bgout; assign a_bclr[1] = bus1.bclr; assign a_valid[1] = bus1.owner_valid;
    assign a_to[1]    = bus1.grant_timeout; assign a_owner[1] = bus1.owner;
    assign a_bgout[2] = bus2.bgout; assign a_bclr[2] = bus2.bclr; assign a_valid[2] = bus2.owner_valid;
    assign a_to[2]    = bus2.grant_timeout; assign a_owner[2] = bus2.owner;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Bus-level model: phase 0 = bus free, 1 = grant offered, 2 = bus held.
    int         ph   [3];
    int         gl   [3];
    int         age  [3];
    int         lst  [3];
    int         own  [3];
    bit         clr  [3];
    bit         tmo  [3];
    logic [3:0] d_br [3][2];
    logic       d_bb [3][2];

    function automatic bit is_rrs(input int m);
        return (m == 1);
    endfunction

    function automatic int pick(input int m, input logic [3:0] req);
        if (!is_rrs(m)) begin
            for (int k = L - 1; k >= 0; k--) if (req[k]) return k;
        end else begin
            for (int i = 1; i <= L; i++) if (req[(lst[m] + i) % L]) return (lst[m] + i) % L;
        end
        return 0;
    endfunction

    always @(posedge clock) begin
        logic [3:0] bs;
        logic [3:0] req;
        logic       bb;
        for (int m = 0; m < 3; m++) begin
            if (m == 2) begin bs = d_br[m][1]; bb = d_bb[m][1]; end
            else        begin bs = br;         bb = bbsy;       end
            if (!reset_n) begin
                d_br[m][0] = 4'hF; d_br[m][1] = 4'hF; d_bb[m][0] = 1'b1; d_bb[m][1] = 1'b1;
            end else begin
                d_br[m][1] = d_br[m][0]; d_br[m][0] = br;
                d_bb[m][1] = d_bb[m][0]; d_bb[m][0] = bbsy;
            end
            req = ~bs;
            if (!reset_n) begin
                ph[m] = 0; gl[m] = 0; age[m] = 0; lst[m] = L - 1; own[m] = 0; clr[m] = 0; tmo[m] = 0;
            end else begin
                tmo[m] = 0;
                case (ph[m])
                    0: if (req != 0 && bb) begin
                           gl[m] = pick(m, req); own[m] = gl[m]; age[m] = 0; ph[m] = 1;
                       end
                    1: if (!bb)                  ph[m] = 2;
                       else if (bs[gl[m]])       ph[m] = 0;
                       else if (age[m] == GT - 1) begin ph[m] = 0; tmo[m] = 1; lst[m] = gl[m]; end
                       else                      age[m]++;
                    default: if (bb) begin ph[m] = 0; clr[m] = 0; lst[m] = gl[m]; end
                             else if (!is_rrs(m) && ((req >> (gl[m] + 1)) != 0)) clr[m] = 1;
                endcase
            end
        end
    end

    logic [3:0] cmp_eb;

    always begin
        @(posedge clock);
        #1;
        for (int m = 0; m < 3; m++) begin
            cmp_eb = 4'hF;
            if (ph[m] == 1) cmp_eb[gl[m]] = 1'b0;
            chk($sformatf("dut%0d_bgout", m), 32'(a_bgout[m]), 32'(cmp_eb));
            chk($sformatf("dut%0d_bclr", m), 32'(a_bclr[m]), 32'(!clr[m]));
            chk($sformatf("dut%0d_owner_valid", m), 32'(a_valid[m]), 32'(ph[m] != 0));
            chk($sformatf("dut%0d_grant_timeout", m), 32'(a_to[m]), 32'(tmo[m]));
            if (ph[m] != 0) chk($sformatf("dut%0d_owner", m), 32'(a_owner[m]), own[m]);
            chk($sformatf("dut%0d_bgout_onehot", m), 32'($countones(~a_bgout[m]) <= 1), 32'd1);
            chk($sformatf("dut%0d_bgout_bclr_excl", m),
                32'(!((a_bgout[m] != 4'hF) && (a_bclr[m] == 1'b0))), 32'd1);
        end
    end

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    int         exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] ev;
    int         n;

    initial begin
        reset_n = 1'b0; br = 4'hF; bbsy = 1'b1;
        repeat (3) after_edge();
        chk("reset_bgout", 32'(a_bgout[0]), 32'hF);
        chk("reset_bclr", 32'(a_bclr[0]), 32'd1);
        chk("reset_valid", 32'(a_valid[0]), 32'd0);
        chk("reset_owner", 32'(a_owner[0]), 32'd0);
        @(negedge clock) reset_n = 1'b1;

        // PRI: levels 0 and 2 request, level 2 wins, then level 0
        @(negedge clock) br = 4'b1010;
        after_edge();
        chk("pri_first_bgout", 32'(a_bgout[0]), 32'hB);
        chk("pri_first_owner", 32'(a_owner[0]), 32'd2);
        @(negedge clock) begin bbsy = 1'b0; br = 4'b1110; end
        after_edge();
        chk("pri_bbsy_release_bg", 32'(a_bgout[0]), 32'hF);
        chk("pri_owned_valid", 32'(a_valid[0]), 32'd1);
        @(negedge clock) bbsy = 1'b1;
        after_edge();
        chk("pri_dead_cycle_valid", 32'(a_valid[0]), 32'd0);
        after_edge();
        chk("pri_second_bgout", 32'(a_bgout[0]), 32'hE);
        @(negedge clock) begin bbsy = 1'b0; br = 4'hF; end
        @(negedge clock) bbsy = 1'b1;
        @(negedge clock);

        // PRI pre-emption: level 1 owns, level 3 requests
        br = 4'b1101;
        after_edge();
        chk("bclr_grant1", 32'(a_bgout[0]), 32'hD);
        @(negedge clock) begin bbsy = 1'b0; br = 4'hF; end
        @(negedge clock) br = 4'b0111;
        after_edge();
        chk("bclr_assert", 32'(a_bclr[0]), 32'd0);
        after_edge();
        chk("bclr_hold", 32'(a_bclr[0]), 32'd0);
        @(negedge clock) bbsy = 1'b1;
        after_edge();
        chk("bclr_release", 32'(a_bclr[0]), 32'd1);
        after_edge();
        chk("bclr_next_grant", 32'(a_bgout[0]), 32'h7);
        chk("bclr_next_owner", 32'(a_owner[0]), 32'd3);
        @(negedge clock) begin bbsy = 1'b0; br = 4'hF; end
        @(negedge clock) bbsy = 1'b1;
        @(negedge clock);

        // Request withdrawn while granted
        br = 4'b1110;
        after_edge();
        chk("withdraw_grant", 32'(a_bgout[0]), 32'hE);
        @(negedge clock) br = 4'hF;
        after_edge();
        chk("withdraw_release", 32'(a_bgout[0]), 32'hF);
        for (int k = 0; k < 10; k++) begin
            chk("withdraw_no_timeout", 32'(a_to[0]), 32'd0);
            after_edge();
        end

        // PRI timeout on level 2; dut2 shows the two-stage sync latency
        @(negedge clock) br = 4'b1011;
        after_edge();
        chk("to_grant", 32'(a_bgout[0]), 32'hB);
        for (int k = 1; k <= 8; k++) begin
            after_edge();
            if (k == 1) chk("sync2_not_yet", 32'(a_bgout[2]), 32'hF);
            if (k == 2) chk("sync2_grant", 32'(a_bgout[2]), 32'hB);
            if (k < 8) begin
                chk("to_bg_held", 32'(a_bgout[0]), 32'hB);
                chk("to_no_pulse", 32'(a_to[0]), 32'd0);
            end else begin
                chk("to_bg_withdrawn", 32'(a_bgout[0]), 32'hF);
                chk("to_pulse", 32'(a_to[0]), 32'd1);
            end
        end
        @(negedge clock) br = 4'hF;
        after_edge();
        chk("to_pulse_single", 32'(a_to[0]), 32'd0);
        repeat (4) @(negedge clock);

        // Reset while owned with bclr asserted
        br = 4'b1101;
        after_edge();
        chk("rst_grant1", 32'(a_bgout[0]), 32'hD);
        @(negedge clock) begin bbsy = 1'b0; br = 4'hF; end
        @(negedge clock) br = 4'b0111;
        after_edge();
        chk("rst_bclr_before", 32'(a_bclr[0]), 32'd0);
        @(negedge clock) reset_n = 1'b0;
        after_edge();
        chk("rst_mid_bgout", 32'(a_bgout[0]), 32'hF);
        chk("rst_mid_bclr", 32'(a_bclr[0]), 32'd1);
        chk("rst_mid_valid", 32'(a_valid[0]), 32'd0);
        chk("rst_mid_owner", 32'(a_owner[0]), 32'd0);
        chk("rst_mid_timeout", 32'(a_to[0]), 32'd0);
        @(negedge clock) begin reset_n = 1'b1; bbsy = 1'b1; br = 4'hF; end
        repeat (4) @(negedge clock);

        // RRS rotation on dut1 with every level requesting
        br = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            after_edge();
            n = 1;
            while (a_bgout[1] == 4'hF && n < 12) begin
                after_edge();
                n++;
            end
            chk("rrs_wait_bound", 32'(n < 12), 32'd1);
            ev = 4'hF;
            ev[exp_seq[i]] = 1'b0;
            chk($sformatf("rrs_order_%0d", i), 32'(a_bgout[1]), 32'(ev));
            chk("rrs_no_bclr", 32'(a_bclr[1]), 32'd1);
            @(negedge clock) bbsy = 1'b0;
            repeat (2) @(negedge clock);
            @(negedge clock) begin
                bbsy = 1'b1;
                if (i == 4) br = 4'hF;
            end
        end
        repeat (4) @(negedge clock);

        // RRS timeout: level 2 dead, level 0 must be served next
        br = 4'b1010;
        after_edge();
        chk("rrs_to_grant2", 32'(a_bgout[1]), 32'hB);
        for (int k = 1; k <= 8; k++) begin
            after_edge();
            if (k == 8) begin
                chk("rrs_to_pulse", 32'(a_to[1]), 32'd1);
                chk("rrs_to_bg_withdrawn", 32'(a_bgout[1]), 32'hF);
            end else begin
                chk("rrs_to_bg_held", 32'(a_bgout[1]), 32'hB);
            end
        end
        after_edge();
        chk("rrs_to_next_level0", 32'(a_bgout[1]), 32'hE);
        @(negedge clock) br = 4'hF;
        repeat (5) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
